// File: rtl/mem_stage_controller.sv
// MEM-stage data-bus controller: ready/request handshake, sub-word lane
// formatting, alignment exceptions and the LL/SC link bit.
module mem_stage_controller (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemByte,
    input  logic        MemHalf,
    input  logic        MemSignExtend,
    input  logic        ReverseEndian,
    input  logic        LLSC,
    input  logic        Flush,
    input  logic        Hold,
    input  logic        Eret,
    input  logic [31:0] DataMem_In,
    input  logic        DataMem_Ready,
    output logic        DataMem_Read,
    output logic [3:0]  DataMem_Write,
    output logic [29:0] DataMem_Address,
    output logic [31:0] DataMem_Out,
    output logic [31:0] ReadData,
    output logic        M_Stall,
    output logic        EXC_AdEL,
    output logic        EXC_AdES
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic        ll_q, ll_d;
    logic [31:0] cap_q, cap_d;

    logic        misaligned;
    logic        sc_write;
    logic        go;
    logic        req;
    logic        xfer_done;
    logic [1:0]  lane_o;
    logic        lane_h;
    logic [3:0]  we;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_fmt;
    logic [31:0] result;

    always_comb begin
        misaligned = MemByte ? 1'b0 : (MemHalf ? Address[0] : (Address[1:0] != 2'b00));
        sc_write   = MemWrite & LLSC;
        go         = (MemRead | MemWrite) & ~misaligned & ~Flush & ~(sc_write & ~ll_q);
        // BUSY keeps the request up regardless of Flush: the bus transfer cannot be aborted
        req        = ((state_q == IDLE) & go) | (state_q == BUSY);
        xfer_done  = req & DataMem_Ready;
        lane_o     = Address[1:0] ^ {2{ReverseEndian}};
        lane_h     = Address[1] ^ ReverseEndian;

        EXC_AdEL   = MemRead & misaligned & ~Flush;
        EXC_AdES   = MemWrite & misaligned & ~Flush;
        M_Stall    = req & ~DataMem_Ready;

        we          = 4'b1111;
        DataMem_Out = WriteData;
        if (MemByte) begin
            we          = 4'b1000 >> lane_o;
            DataMem_Out = {4{WriteData[7:0]}};
        end else if (MemHalf) begin
            we          = lane_h ? 4'b0011 : 4'b1100;
            DataMem_Out = {2{WriteData[15:0]}};
        end
        DataMem_Read    = req & MemRead;
        DataMem_Write   = (req & MemWrite) ? we : 4'b0000;
        DataMem_Address = Address[31:2];

        // Lane 0 is the most significant byte (big-endian numbering)
        case (lane_o)
            2'd0:    byte_sel = DataMem_In[31:24];
            2'd1:    byte_sel = DataMem_In[23:16];
            2'd2:    byte_sel = DataMem_In[15:8];
            default: byte_sel = DataMem_In[7:0];
        endcase
        half_sel = lane_h ? DataMem_In[15:0] : DataMem_In[31:16];

        if (MemByte)
            load_fmt = {{24{MemSignExtend & byte_sel[7]}}, byte_sel};
        else if (MemHalf)
            load_fmt = {{16{MemSignExtend & half_sel[15]}}, half_sel};
        else
            load_fmt = DataMem_In;

        result   = sc_write ? {31'd0, req} : load_fmt;
        ReadData = (state_q == DONE) ? cap_q : result;
    end

    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        ll_d    = ll_q;

        if (xfer_done & MemRead & LLSC)
            ll_d = 1'b1;
        else if ((xfer_done & sc_write) | Eret)
            ll_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (go & ~DataMem_Ready)
                    state_d = BUSY;
                else if (go & Hold) begin
                    state_d = DONE;
                    cap_d   = result;
                end
            end
            BUSY: begin
                if (DataMem_Ready) begin
                    state_d = Hold ? DONE : IDLE;
                    if (Hold)
                        cap_d = result;
                end
            end
            DONE: begin
                if (~Hold)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ll_q    <= 1'b0;
            cap_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            ll_q    <= ll_d;
            cap_q   <= cap_d;
        end
    end

endmodule

// File: doc/mem_stage_controller.md
# mem_stage_controller

Memory-stage data-bus controller that sits directly behind the EX/MEM pipeline register and consumes its memory-control outputs. It turns one load/store per instruction into a ready/request handshake on the data-memory port, formats sub-word data, checks alignment, and implements the LL/SC link bit. It drives `M_Stall` back to the pipeline registers while a transfer is outstanding.

## Interface
- No parameters.
- `clock` — in, 1, pipeline clock.
- `reset` — in, 1, asynchronous, active-high.
- `Address` — in, 32, effective address (`M_ALU_Result`).
- `WriteData` — in, 32, store data (`M_ReadData2`).
- `MemRead` / `MemWrite` — in, 1 each, load or store present (never both).
- `MemByte` / `MemHalf` — in, 1 each, byte or halfword size; both low means word.
- `MemSignExtend` — in, 1, sign-extend sub-word loads.
- `ReverseEndian` — in, 1, little-endian lane mapping.
- `LLSC` — in, 1, the access is LL (with `MemRead`) or SC (with `MemWrite`).
- `Flush` — in, 1, the instruction is being killed; suppresses issue.
- `Hold` — in, 1, an external stall keeps the current instruction in M.
- `Eret` — in, 1, clears the LL bit.
- `DataMem_In` — in, 32, read data.
- `DataMem_Ready` — in, 1, transfer complete this cycle.
- `DataMem_Read` — out, 1, read request.
- `DataMem_Write` — out, 4, byte-lane write enables; bit 3 is bits 31:24.
- `DataMem_Address` — out, 30, equals `Address[31:2]`.
- `DataMem_Out` — out, 32, lane-replicated write data.
- `ReadData` — out, 32, formatted load result or SC result, to the MEM/WB register.
- `M_Stall` — out, 1, stall request to the pipeline.
- `EXC_AdEL` / `EXC_AdES` — out, 1 each, load or store address error.

## Operation
- Size and alignment:
  - Misaligned halfword: `Address[0]=1`.
  - Misaligned word: `Address[1:0]!=0`.
  - Misaligned with `~Flush`: `EXC_AdEL` for a read, `EXC_AdES` for a write. Both are combinational.
  - A misaligned access issues no request and asserts no stall.
- `Go` = (`MemRead` | `MemWrite`) & aligned & `~Flush` & ~(SC with LL bit clear).
- Lane offset:
  - Byte: `o = Address[1:0] ^ {2{ReverseEndian}}`.
  - Half: `h = Address[1] ^ ReverseEndian`.
  - Offset 0 selects bits 31:24 (big-endian).
- Write enables:
  - Byte: one-hot `4'b1000 >> o`.
  - Half: `4'b1100` when `h=0`, `4'b0011` when `h=1`.
  - Word: `4'b1111`.
  - `0000` whenever no write request is active.
- `DataMem_Out`: byte replicated ×4, half replicated ×2, word unchanged.
- Load format: select the lane, then sign- or zero-extend per `MemSignExtend`.
- FSM states:
  - IDLE:
    - Requests asserted iff `Go`.
    - `Go & DataMem_Ready` and `Hold` → DONE.
    - `Go & DataMem_Ready` and `~Hold` → stay IDLE.
    - `Go & ~DataMem_Ready` → BUSY.
  - BUSY:
    - Requests held asserted, with address and data stable.
    - `DataMem_Ready` with `Hold` → DONE; with `~Hold` → IDLE.
    - `Flush` and `Hold` do not abort the transfer.
  - DONE:
    - No requests; `ReadData` comes from the captured register.
    - `~Hold` → IDLE.
- `M_Stall` = request active & `~DataMem_Ready` (Mealy).
- `ReadData` source:
  - DONE: the captured register.
  - Load: formatted `DataMem_In`.
  - SC: 1 if the write is issued or complete, 0 if suppressed.
- LL bit:
  - Set when an LL completes (Ready seen).
  - Cleared when an SC completes, or when `Eret` is high.
  - If `Eret` and an LL completion occur together, set wins.
- Suppressed SC (LL bit clear): no bus write, no stall, `ReadData=0`.

## Timing
- Reset, asynchronous:
  - State → IDLE; LL bit → 0; capture register → 0.
  - Requests deassert immediately, including mid-BUSY.
  - `M_Stall`=0 unless a new `Go` is present.
- Latency:
  - Zero-wait memory (Ready in the request cycle): no stall cycle.
  - N wait cycles: `M_Stall` high for exactly N cycles.
- The capture register loads formatted data (or the SC result) on the Ready edge only when entering DONE.
- Exceptions and `M_Stall` are combinational from inputs and state. There are no registered outputs other than `ReadData` in DONE.

## Test plan
- Aligned word load, `Address=0x100`, Ready after 2 cycles:
  - `DataMem_Read` high 3 cycles, `M_Stall` high 2 cycles.
  - `DataMem_In=0xDEADBEEF` → `ReadData=0xDEADBEEF`.
- Signed byte load, `Address=0x101`, `DataMem_In=0x0080FF00`:
  - Big-endian: `ReadData=0xFFFFFF80`.
  - With `ReverseEndian=1` (lane 2): `ReadData=0xFFFFFFFF`.
  - Unsigned, big-endian: `ReadData=0x00000080`.
- Halfword store, `Address=0x102`, `WriteData=0x1234ABCD`:
  - `DataMem_Write=0011`, `DataMem_Out=0xABCDABCD`, `DataMem_Address=0x40`.
- Misaligned accesses:
  - Word load at `0x103` → `EXC_AdEL=1`, no request, `M_Stall=0`.
  - Same with `Flush=1` → no exception.
- LL/SC sequence:
  - LL completes, then SC → write issued, `ReadData=1`.
  - Second SC → no write, `ReadData=0`, no stall.
  - LL, `Eret`, SC → `ReadData=0`.
- `Hold` high across a Ready cycle of a load:
  - FSM enters DONE; `ReadData` stays captured while `DataMem_In` changes.
  - No re-issue; returns to IDLE when `Hold` falls.
  - Reset asserted mid-BUSY drops `DataMem_Read` in the same cycle.
